// File: rtl/fft_bitrev_reorder.sv
// Purpose : ping-pong frame buffer that replays each N-sample frame in bit-reversed or natural order.
// Latency : first output N+1 cycles after the first sample of a contiguous frame; last output at 2N.
// Backpressure: none; a frame cannot complete before the previous readout has finished.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   enable, in_sof      sample valid and frame-start marker (in_sof only meaningful with enable)
//   bitrev_en           readout order for the frame being swapped in (1 = bit-reversed)
//   xb_re, xb_im        signed input sample
//   Xb_re, Xb_im        registered reordered sample, held while out_valid is low
//   out_valid/sof/eof   output qualifiers and frame markers
//   frame_err           sticky truncated-frame flag, cleared only by reset
module fft_bitrev_reorder #(
    parameter int W     = 16,
    parameter int LOG2N = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                in_sof,
    input  logic                bitrev_en,
    input  logic signed [W-1:0] xb_re,
    input  logic signed [W-1:0] xb_im,
    output logic signed [W-1:0] Xb_re,
    output logic signed [W-1:0] Xb_im,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    output logic                frame_err
);

    localparam int N = 1 << LOG2N;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    localparam logic [LOG2N-1:0] IDX_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] IDX_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};

    // Both banks live in one array; the MSB of the address is the bank.
    logic [2*W-1:0]   mem [0:2*N-1];

    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] wr_addr;
    logic [LOG2N-1:0] rd_idx;
    logic [LOG2N-1:0] rd_addr;
    logic [0:0]       state;
    logic             bank_sel;   // bank currently being written; the other one is read
    logic             mode;       // readout order latched for the frame being read
    logic             wr_fire;
    logic             swap;
    logic [2*W-1:0]   rd_word;

    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    always_comb begin
        wr_fire = rst && enable;
        // A start-of-frame sample always lands at address 0, discarding any partial frame.
        wr_addr = in_sof ? '0 : wr_idx;
        swap    = wr_fire && (wr_addr == IDX_LAST);
        rd_addr = mode ? bit_reverse(rd_idx) : rd_idx;
        rd_word = mem[{~bank_sel, rd_addr}];
    end

    // Storage has no reset; stale contents are never read because reset drops the FSM to idle.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{bank_sel, wr_addr}] <= {xb_re, xb_im};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            state     <= S_IDLE;
            mode      <= 1'b0;
            bank_sel  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_err <= 1'b0;
            Xb_re     <= '0;
            Xb_im     <= '0;
        end else begin
            if (wr_fire) begin
                wr_idx <= in_sof ? IDX_ONE : wr_idx + 1'b1;
                if (in_sof && (wr_idx != '0)) begin
                    frame_err <= 1'b1;
                end
            end

            if (swap) begin
                bank_sel <= ~bank_sel;
                mode     <= bitrev_en;
            end

            // Output stage: one register after the address is issued.
            out_valid <= (state == S_READ);
            out_sof   <= (state == S_READ) && (rd_idx == '0);
            out_eof   <= (state == S_READ) && (rd_idx == IDX_LAST);
            if (state == S_READ) begin
                {Xb_re, Xb_im} <= rd_word;
            end

            case (state)
                S_IDLE: begin
                    if (swap) begin
                        state  <= S_READ;
                        rd_idx <= '0;
                    end
                end
                S_READ: begin
                    if (rd_idx == IDX_LAST) begin
                        // A swap on the last read cycle chains straight into the next frame.
                        rd_idx <= '0;
                        if (!swap) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    rd_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Purpose : self-checking bench for fft_bitrev_reorder (N=8 table vectors plus an N=1024 reset case).
// Latency : expected outputs are queued when a frame completes and popped as the DUT emits them.
// Backpressure: none; the bench only bounds every wait with a cycle budget.
module tb_fft_bitrev_reorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- small DUT, N = 8 ----------------
    logic               rst_n, enable, in_sof, bitrev_en;
    logic signed [15:0] xb_re, xb_im, Xb_re, Xb_im;
    logic               out_valid, out_sof, out_eof, frame_err;

    fft_bitrev_reorder #(.W(16), .LOG2N(3)) u_dut (
        .clk(clk), .rst(rst_n), .enable(enable), .in_sof(in_sof), .bitrev_en(bitrev_en),
        .xb_re(xb_re), .xb_im(xb_im), .Xb_re(Xb_re), .Xb_im(Xb_im),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .frame_err(frame_err)
    );

    // ---------------- big DUT, default N = 1024 ----------------
    logic               b_rst, b_en, b_sof, b_brev;
    logic signed [15:0] b_re, b_im, b_Xre, b_Xim;
    logic               b_valid, b_osof, b_oeof, b_ferr;

    fft_bitrev_reorder #(.W(16)) u_big (
        .clk(clk), .rst(b_rst), .enable(b_en), .in_sof(b_sof), .bitrev_en(b_brev),
        .xb_re(b_re), .xb_im(b_im), .Xb_re(b_Xre), .Xb_im(b_Xim),
        .out_valid(b_valid), .out_sof(b_osof), .out_eof(b_oeof), .frame_err(b_ferr)
    );

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sof;
        logic        eof;
    } exp_t;

    typedef struct packed {
        logic            brev;
        logic            tog;
        logic            sof;
        logic [7:0]      base;
        logic [7:0][2:0] perm;
        logic [7:0]      lat;
    } vec_t;

    exp_t sb[$];
    int   sof_cyc[$];
    exp_t mon_e;
    int   run = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the small DUT, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%0d required=no output (cycle %0d)", Xb_re, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("small_out", {30'd0, Xb_re, Xb_im, out_sof, out_eof},
                      {30'd0, mon_e.re, mon_e.im, mon_e.sof, mon_e.eof});
                if (out_sof) sof_cyc.push_back(cyc);
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;                // must be ignored while in reset
        in_sof = 1'b0;
        xb_re = 16'sh7777;
        xb_im = 16'sh1234;
        step();
        step();
        rst_n = 1'b1;
        enable = 1'b0;
        sb.delete();
        sof_cyc.delete();
        max_run = 0;
        check("reset_state", {Xb_re, Xb_im, 28'd0, out_valid, out_sof, out_eof, frame_err}, 64'd0);
    endtask

    // Drives one 8-sample ramp; returns the cycle its first sample was presented.
    task automatic send_frame(input logic [7:0] base, input logic sof, input logic tog,
                              input logic brev, input logic [7:0][2:0] perm, output int t_in);
        exp_t e;
        logic [15:0] v;
        for (int k = 0; k < 8; k++) begin
            if (tog && k > 0) begin
                enable = 1'b0;
                in_sof = 1'b1;        // ignored without enable
                step();
            end
            if (k == 0) t_in = cyc;
            enable    = 1'b1;
            in_sof    = sof && (k == 0);
            bitrev_en = brev;
            xb_re     = 16'(base + 8'(k));
            xb_im     = -16'(base + 8'(k));
            step();
        end
        enable    = 1'b0;
        in_sof    = 1'b0;
        bitrev_en = ~brev;            // order is latched at the swap, later changes must not matter
        for (int k = 0; k < 8; k++) begin
            v = 16'(base + 8'(perm[k]));
            e.re = v;
            e.im = -v;
            e.sof = (k == 0);
            e.eof = (k == 7);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        step();
        step();
        step();
    endtask

    function automatic int brev10(input int j);
        int r;
        r = 0;
        for (int b = 0; b < 10; b++) if (j[b]) r |= (1 << (9 - b));
        return r;
    endfunction

    function automatic logic [15:0] tone(input int k);
        return k[4] ? 16'sd20000 : -16'sd20000;
    endfunction

    vec_t vecs[5];
    logic [7:0][2:0] p_brev, p_nat;

    initial begin
        int t_in, t_in2, t0, viol, found;
        p_brev = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};
        p_nat  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        //           brev  tog   sof   base   perm    lat
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0,  p_brev, 8'd9};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'd0,  p_brev, 8'd9};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'd0,  p_nat,  8'd9};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'd0,  p_brev, 8'd16};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'd50, p_nat,  8'd16};

        enable = 0; in_sof = 0; bitrev_en = 0; xb_re = 0; xb_im = 0; rst_n = 0;
        b_rst = 0; b_en = 0; b_sof = 0; b_brev = 1; b_re = 0; b_im = 0;

        // ---- table-driven single frames ----
        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_frame(vecs[i].base, vecs[i].sof, vecs[i].tog, vecs[i].brev, vecs[i].perm, t_in);
            wait_drain();
            check($sformatf("v%0d_nframes", i), sof_cyc.size(), 1);
            if (sof_cyc.size() == 1)
                check($sformatf("v%0d_latency", i), sof_cyc[0] - t_in, vecs[i].lat);
            check($sformatf("v%0d_hold", i), {out_valid, Xb_re},
                  {1'b0, 16'(vecs[i].base + 8'(vecs[i].perm[7]))});
        end

        // ---- back-to-back frames, no bubble ----
        do_reset();
        send_frame(8'd0, 1'b1, 1'b0, 1'b1, p_brev, t_in);
        send_frame(8'd8, 1'b1, 1'b0, 1'b1, p_brev, t_in2);
        wait_drain();
        check("b2b_run", max_run, 16);
        check("b2b_nframes", sof_cyc.size(), 2);
        if (sof_cyc.size() == 2) check("b2b_gap", sof_cyc[1] - sof_cyc[0], 8);

        // ---- truncated frame ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            enable = 1'b1;
            in_sof = (k == 0);
            bitrev_en = 1'b1;
            xb_re = 16'(100 + k);
            xb_im = 16'(200 + k);
            step();
        end
        check("err_before", frame_err, 0);
        send_frame(8'd40, 1'b1, 1'b0, 1'b1, p_brev, t_in);
        check("err_set", frame_err, 1);
        wait_drain();
        check("err_nframes", sof_cyc.size(), 1);
        if (sof_cyc.size() == 1) check("err_latency", sof_cyc[0] - t_in, 9);
        check("err_sticky", frame_err, 1);

        // ---- N = 1024, reset during readout ----
        step();
        b_rst = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 1024; k++) begin
            b_en = 1'b1; b_sof = (k == 0); b_re = tone(k); b_im = 16'(k);
            step();
        end
        b_en = 1'b0; b_sof = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (b_valid) found = 1; else step();
        end
        check("big1_latency", found ? cyc - t0 : -1, 1025);
        if (found) begin
            for (int j = 0; j <= 500; j++) begin
                @(negedge clk);
                check("big1_out", {15'd0, b_valid, b_osof, b_Xre, b_Xim},
                      {15'd0, 1'b1, (j == 0), tone(brev10(j)), 16'(brev10(j))});
            end
            b_rst = 1'b0;             // asserted while output sample 500 is on the bus
            step();
            b_rst = 1'b1;
            check("big_rst_valid", b_valid, 0);
            viol = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (b_valid) viol++;
            end
            t0 = cyc;
            for (int k = 0; k < 1024; k++) begin
                b_en = 1'b1; b_sof = (k == 0); b_re = tone(k); b_im = 16'(k + 3000);
                step();
                if (b_valid) viol++;
            end
            b_en = 1'b0; b_sof = 1'b0;
            check("big_quiet", viol, 0);
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (b_valid) found = 1; else step();
            end
            check("big2_latency", found ? cyc - t0 : -1, 1025);
            for (int j = 0; j < 8; j++) begin
                check("big2_out", {31'd0, b_valid, b_Xre, b_Xim},
                      {31'd0, 1'b1, tone(brev10(j)), 16'(brev10(j) + 3000)});
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
